// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage registers.
//   DW_DEF / CW_DEF / CNT_W_DEF : default data, control and stall-counter widths.
//   CTRL_*                      : bit positions inside the control payload.
//   pipe_entry_t                : {valid, data, ctrl} layout of one held entry
//                                 at the default widths; stages built with other
//                                 widths use a local struct of the same layout.
package pipe_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned CW_DEF    = 8;
  localparam int unsigned CNT_W_DEF = 32;

  // Control payload bit positions.
  localparam int unsigned CTRL_W_RF      = 0;  // register-file write enable
  localparam int unsigned CTRL_W_HI      = 1;  // HI write enable
  localparam int unsigned CTRL_W_LO      = 2;  // LO write enable
  localparam int unsigned CTRL_RFSRC_LSB = 3;  // rf write-data source select
  localparam int unsigned CTRL_RFSRC_W   = 2;
  localparam int unsigned CTRL_ASEL      = 5;  // ALU operand A select
  localparam int unsigned CTRL_BSEL      = 6;  // ALU operand B select
  localparam int unsigned CTRL_MEMRD     = 7;  // memory read

  typedef struct packed {
    logic              valid;
    logic [DW_DEF-1:0] data;
    logic [CW_DEF-1:0] ctrl;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_stall_cnt.sv
// pipe_stall_cnt: saturating up-counter of stalled cycles.
//   clk  : clock
//   rst  : asynchronous active-high reset, clears the count
//   inc  : count this cycle
//   cnt  : current count, sticks at all-ones
module pipe_stall_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready handshake,
// synchronous flush, bubble-gated control and saturating stall counter.
// Optional feature macro: PIPE_SKID_EN (adds a second, skid entry and makes
// in_ready a register output; otherwise in_ready = !out_valid || out_ready).
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : synchronous kill of all held entries
//   in_valid/in_ready   : upstream handshake, in_data / in_ctrl payload
//   out_valid/out_ready : downstream handshake, out_data / out_ctrl payload
//   stall_cnt           : cycles with out_valid && !out_ready (saturating)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [CW-1:0]    in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_ctrl,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } entry_t;

  entry_t main_q;
  entry_t in_entry;
  logic   in_xfer;
  logic   drain;

  assign in_entry = {1'b1, in_data, in_ctrl};
  assign drain    = main_q.valid && out_ready;
  assign in_xfer  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  entry_t skid_q;

  // skid_q.valid is a flop, so in_ready has no path from out_ready.
  assign in_ready = !skid_q.valid;

  // A full skid blocks input, so skid->main and in->main never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
    end else if (drain) begin
      if (skid_q.valid) begin
        main_q       <= skid_q;
        skid_q.valid <= 1'b0;
      end else if (in_xfer) begin
        main_q <= in_entry;
      end else begin
        main_q.valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (main_q.valid) begin
        skid_q <= in_entry;
      end else begin
        main_q <= in_entry;
      end
    end
  end
`else
  assign in_ready = !main_q.valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
    end else if (flush) begin
      main_q.valid <= 1'b0;
    end else if (in_xfer) begin
      main_q <= in_entry;
    end else if (drain) begin
      main_q.valid <= 1'b0;
    end
  end
`endif

  assign out_valid = main_q.valid;
  assign out_data  = main_q.data;
  // Bubbles carry all-zero control so they never write rf/hi/lo.
  assign out_ctrl  = main_q.ctrl & {CW{main_q.valid}};

  pipe_stall_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (main_q.valid && !out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// A second instance with CNT_W=4 shares all inputs and is used for the
// counter saturation case.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [31:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [7:0]  s_out_ctrl;
  logic [3:0]  s_stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic        last_acc;
  logic        last_out;
  logic [31:0] last_out_data;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DW(32), .CW(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DW(32), .CW(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples both handshakes at the falling edge, then returns 1 time unit
  // after the next rising edge, where inputs are driven and outputs checked.
  task automatic tick();
    @(negedge clk);
    last_acc      = in_valid && in_ready;
    last_out      = out_valid && out_ready;
    last_out_data = out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] vec [3];
    logic [31:0] got [$];
    int unsigned idx;
    int unsigned n_out;

    vec[0] = 32'hA; vec[1] = 32'hB; vec[2] = 32'hC;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // ---- asynchronous reset with an entry held ----
    in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h3C; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_ctrl", out_ctrl, 8'h3C);
    check("pre_rst_stall", stall_cnt, 2);
    #3 rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    tick();
    check("rst_held_valid", out_valid, 0);
    rst = 1'b0;
    tick();

    // ---- streaming ----
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h01;
    in_data = 32'h10; tick(); check("stream_0", out_data, 32'h10);
    in_data = 32'h14; tick(); check("stream_1", out_data, 32'h14);
    check("stream_1_valid", out_valid, 1);
    in_data = 32'h18; tick(); check("stream_2", out_data, 32'h18);
    in_valid = 1'b0;
    tick();
    check("stream_done_valid", out_valid, 0);
    check("stream_stall", stall_cnt, 0);

    // ---- back-pressure ----
    rst = 1'b1; #1 rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h02;
    idx = 0; in_data = vec[0];
    repeat (4) begin
      tick();
      if (last_acc) idx++;
      if (idx < 3) in_data = vec[idx]; else in_valid = 1'b0;
    end
    check("bp_head", out_data, 32'hA);
    check("bp_in_ready", in_ready, 0);
    check("bp_stall", stall_cnt, 3);
`ifdef PIPE_SKID_EN
    check("bp_accepted", idx, 2);
`else
    check("bp_accepted", idx, 1);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 20 && got.size() < 3; k++) begin
      tick();
      if (last_out) got.push_back(last_out_data);
      if (last_acc) idx++;
      if (idx < 3) in_data = vec[idx]; else in_valid = 1'b0;
    end
    check("bp_count", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) check($sformatf("bp_order_%0d", k), got[k], vec[k]);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("bp_drained", out_valid, 0);

    // ---- flush ----
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF;
    in_data = 32'h21; tick();
`ifdef PIPE_SKID_EN
    in_data = 32'h22; tick();
`endif
    check("fl_pre_ctrl", out_ctrl, 8'hFF);
    in_data = 32'h99; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, 8'h00);
    check("fl_in_ready", in_ready, 1);
    n_out = 0;
    repeat (4) begin
      tick();
      if (last_out) n_out++;
    end
    check("fl_no_emit", n_out, 0);

    // ---- simultaneous drain and fill ----
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1; in_ctrl = 8'h05;
    tick();
    out_ready = 1'b1; in_data = 32'h2; in_ctrl = 8'h06;
    tick();
    in_valid = 1'b0;
    check("df_consumed", last_out_data, 32'h1);
    check("df_took", last_out, 1);
    check("df_data", out_data, 32'h2);
    check("df_valid", out_valid, 1);
    check("df_ctrl", out_ctrl, 8'h06);
    tick();
    check("df_empty", out_valid, 0);

    // ---- saturation (CNT_W=4 instance) ----
    #2 rst = 1'b1; #1 rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h01;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    check("sat_14", s_stall_cnt, 14);
    tick();
    check("sat_15", s_stall_cnt, 15);
    repeat (5) tick();
    check("sat_hold", s_stall_cnt, 15);
    check("wide_20", stall_cnt, 20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("sat_after_flush", s_stall_cnt, 15);
    check("wide_after_flush", stall_cnt, 21);
    check("sat_flush_valid", s_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
